// File: rtl/tt_pkg.sv
// Shared types and constants for the truth-table extractor.
package tt_pkg;

  localparam int N_IN_DEFAULT = 4;
  localparam int CNT_W        = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } state_e;

  function automatic int tt_width(input int n_in);
    return 1 << n_in;
  endfunction

endpackage

// File: rtl/tt_settle_timer.sv
// Loadable down-counter that flags terminal count while it holds zero.
module tt_settle_timer
  import tt_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [CNT_W-1:0] value_i,
  input  logic             dec_i,
  output logic             tc_o
);

  logic [CNT_W-1:0] count_q, count_d;

  // A load takes precedence over a decrement; the count parks at zero.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = value_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc_o = (count_q == '0);

endmodule

// File: rtl/tt_extractor.sv
// Sweeps every input combination into a gate, samples its output after a
// settle delay, assembles the truth-table code and compares it to an expected code.
module tt_extractor
  import tt_pkg::*;
#(
  parameter  int N_IN   = N_IN_DEFAULT,
  parameter  int SETTLE = 2,
  localparam int TT_W   = tt_width(N_IN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic [TT_W-1:0] expected_tt,
  output logic [N_IN-1:0] dut_in,
  input  logic            dut_out,
  output logic            busy,
  output logic            done,
  output logic [TT_W-1:0] tt,
  output logic            match
);

  localparam logic [CNT_W-1:0] SettleLoad = CNT_W'((SETTLE == 0) ? 0 : SETTLE - 1);
  localparam logic [N_IN:0]    LastIdx    = (N_IN+1)'(TT_W - 1);

  state_e          state_q, state_d;
  logic [N_IN:0]   idx_q, idx_d;
  logic [TT_W-1:0] tt_q, tt_d;
  logic [TT_W-1:0] exp_q, exp_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            match_q, match_d;
  logic            tmrLoad, tmrDec, tmrTc;

  tt_settle_timer u_timer (
    .clk     (clk),
    .rst     (rst),
    .load_i  (tmrLoad),
    .value_i (SettleLoad),
    .dec_i   (tmrDec),
    .tc_o    (tmrTc)
  );

  // Abort outranks every transition; in IDLE it only suppresses a start.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    tt_d    = tt_q;
    exp_d   = exp_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    match_d = match_q;
    tmrLoad = 1'b0;
    tmrDec  = 1'b0;

    if (abort) begin
      if (state_q != ST_IDLE) begin
        state_d = ST_IDLE;
        idx_d   = '0;
        busy_d  = 1'b0;
        match_d = 1'b0;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            exp_d   = expected_tt;
            tt_d    = '0;
            match_d = 1'b0;
            idx_d   = '0;
            busy_d  = 1'b1;
            if (SETTLE == 0) begin
              state_d = ST_SAMPLE;
            end else begin
              state_d = ST_SETTLE;
              tmrLoad = 1'b1;
            end
          end
        end
        ST_SETTLE: begin
          if (tmrTc) begin
            state_d = ST_SAMPLE;
          end else begin
            tmrDec = 1'b1;
          end
        end
        ST_SAMPLE: begin
          tt_d[idx_q[N_IN-1:0]] = dut_out;
          if (idx_q == LastIdx) begin
            state_d = ST_DONE;
          end else begin
            idx_d = idx_q + 1'b1;
            if (SETTLE == 0) begin
              state_d = ST_SAMPLE;
            end else begin
              state_d = ST_SETTLE;
              tmrLoad = 1'b1;
            end
          end
        end
        ST_DONE: begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          match_d = (tt_q == exp_q);
          idx_d   = '0;
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      tt_q    <= '0;
      exp_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      match_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      tt_q    <= tt_d;
      exp_q   <= exp_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      match_q <= match_d;
    end
  end

  assign dut_in = idx_q[N_IN-1:0];
  assign busy   = busy_q;
  assign done   = done_q;
  assign tt     = tt_q;
  assign match  = match_q;

endmodule

// File: doc/tt_extractor.md
Name: tt_extractor

Overview:
Sequential truth-table reader for the synthesized 4-input single-output gate netlists (inputs _0.._3, output _4). It sweeps all 16 input combinations into a gate under test and waits a programmable settle time per combination. It samples the gate output and assembles the 16-bit truth-table code used to name designs (e.g. 0x1AC6), then compares it against an expected code. It sits in the characterization/regression harness alongside the gate netlists.

Parameters:
N_IN, 4, number of gate inputs; truth-table width TT_W = 2**N_IN (16).
SETTLE, 2, clock cycles dut_in is held before dut_out is sampled; legal range 0..255.

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  request a sweep; sampled only in IDLE
abort  input  1  terminate the sweep in progress; returns to IDLE without asserting done
expected_tt  input  TT_W  expected truth-table code; latched on accepted start
dut_in  output  N_IN  drives gate inputs; bit k drives input _k
dut_out  input  1  gate output (_4)
busy  output  1  high from accepted start until done/abort
done  output  1  one-cycle pulse when tt is valid
tt  output  TT_W  extracted truth table; tt[i] = f(dut_in = i)
match  output  1  (tt == latched expected), valid with done and held until next accepted start

Behaviour:
- Reset (async assert, sync release): state IDLE; dut_in=0, busy=0, done=0, tt=0, match=0, counters=0.
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE: start=1 -> latch expected_tt; clear tt and match; idx=0; dut_in=0; busy=1; go to SETTLE (or SAMPLE if SETTLE=0).
- SETTLE: hold dut_in=idx for SETTLE cycles (down-counter loaded with SETTLE-1); go to SAMPLE on terminal count.
- SAMPLE (1 cycle): tt[idx] <= dut_out. If idx == TT_W-1 -> DONE. Else idx++ and dut_in <= idx+1 in the same edge -> SETTLE.
- DONE (1 cycle): done=1, busy=0 this cycle; match <= (tt with final bit) == expected; dut_in <= 0; -> IDLE.
- Latency: accepted start to done = TT_W*(SETTLE+1)+1 cycles (49 for defaults).
- idx is N_IN+1 bits wide internally so there is no wrap ambiguity; dut_in = idx[N_IN-1:0].
- start while busy: ignored, and expected_tt is not re-latched.
- abort has priority over every transition, including SAMPLE of the last index. Next state IDLE, busy=0, done stays 0, dut_in=0, tt keeps its partial bits, match=0.
- start and abort together in IDLE: abort wins and start is dropped.
- rst mid-sweep: immediate return to reset values; no done pulse.
- tt and match are stable between sweeps. tt bits not yet sampled read 0 while busy.

Decomposition:
- Package tt_pkg: state enum (IDLE, SETTLE, SAMPLE, DONE), N_IN default, TT_W derivation function, SETTLE counter width constant (8).
- One natural sub-module: tt_settle_timer, a loadable down-counter with terminal-count flag, clk/rst, width from tt_pkg.
- Everything else (FSM, idx, tt shift/assembly, compare) lives in tt_extractor.

Test Plan:
- 0x1AC6 gate netlist on dut_in/dut_out, expected_tt=16'h1AC6, pulse start -> done at cycle 49 after start; tt=16'h1AC6, match=1; dut_in steps 0..15, each held 3 cycles.
- Same gate, expected_tt=16'h1AC7 -> tt=16'h1AC6, match=0.
- dut_out tied 0, then tied 1, with SETTLE=0 -> tt=16'h0000 then 16'hFFFF; done 17 cycles after start.
- Assert rst at cycle 20 of a sweep -> busy, dut_in, tt and match read 0 the same cycle with no done. A new start after release gives the full correct result.
- Assert abort in the SAMPLE cycle of idx=15 -> no done pulse; busy=0; match=0; tt[15]=0, with lower bits holding the sampled values.
- Pulse start at cycle 10 of a busy sweep with a different expected_tt -> ignored; done at the original cycle 49, compared against the originally latched code.
